// File: rtl/ysyx_23060332_lsu.sv
// Multi-cycle load/store unit: valid/ready front end to execute, variable-latency
// memory port behind, lane alignment for stores and extract/extend for loads.
module ysyx_23060332_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  wmask_r;
    logic [1:0]  size_r;
    logic        wen_r;
    logic        uns_r;
    logic [31:0] rdata_r;
    logic        err_r;

    logic        misaligned;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wmask;
    logic [31:0] shifted;
    logic [31:0] load_val;

    always_comb begin
        misaligned = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (|req_addr[1:0]));
    end

    always_comb begin
        lane_wdata = req_wdata;
        lane_wmask = 4'b1111;
        case (req_size)
            2'b00: begin
                lane_wdata = {4{req_wdata[7:0]}};
                lane_wmask = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{req_wdata[15:0]}};
                lane_wmask = 4'b0011 << req_addr[1:0];
            end
            default: ;
        endcase
    end

    // Move the addressed byte/half down to bit 0 before extending.
    always_comb begin
        shifted  = mem_rsp_rdata >> {addr_r[1:0], 3'b000};
        load_val = mem_rsp_rdata;
        case (size_r)
            2'b00: load_val = uns_r ? {24'b0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: load_val = uns_r ? {16'b0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            addr_r  <= '0;
            wdata_r <= '0;
            wmask_r <= '0;
            size_r  <= '0;
            wen_r   <= 1'b0;
            uns_r   <= 1'b0;
            rdata_r <= '0;
            err_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_r  <= req_addr;
                        wdata_r <= lane_wdata;
                        wmask_r <= (req_wen && !misaligned) ? lane_wmask : 4'b0000;
                        size_r  <= req_size;
                        wen_r   <= req_wen;
                        uns_r   <= req_unsigned;
                        rdata_r <= '0;
                        err_r   <= misaligned;
                        state   <= misaligned ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (!wen_r) rdata_r <= load_val;
                        state <= S_DONE;
                    end
                end
                default: begin
                    if (resp_ready) state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = (state == S_IDLE);
    assign mem_req_valid = (state == S_REQ);
    assign mem_addr      = {addr_r[31:2], 2'b00};
    assign mem_wen       = (state == S_REQ) & wen_r;
    assign mem_wdata     = wdata_r;
    assign mem_wmask     = (state == S_REQ) ? wmask_r : 4'b0000;
    assign resp_valid    = (state == S_DONE);
    assign resp_rdata    = rdata_r;
    assign resp_err      = err_r;

endmodule

// File: doc/ysyx_23060332_lsu.md
# ysyx_23060332_lsu

Multi-cycle load/store unit between the execute stage and the data memory port. It accepts one memory operation per transaction: byte, halfword or word; load or store; signed or unsigned. It runs a valid/ready request and response exchange with a variable-latency memory, aligns store data and byte masks, and extracts and extends load data. It returns the result to write-back through a valid/ready response. Misaligned accesses are rejected locally and never reach memory.

## Interface
- No parameters. Data and address width is fixed at 32; the byte mask is fixed at 4 bits.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req_valid  in  1  execute stage presents an operation.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and handled as misaligned.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  32  req_addr with bits [1:0] cleared.
- mem_wen  out  1  store request.
- mem_wdata  out  32  store data shifted into byte lanes.
- mem_wmask  out  4  byte-lane enables; 0 for loads.
- mem_rsp_valid  in  1  memory response, 1 cycle. For loads it carries read data; for stores it is the write acknowledge.
- mem_rsp_rdata  in  32  aligned read word.
- resp_valid  out  1  result available to write-back.
- resp_ready  in  1  write-back consumes the result.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  access was misaligned or had an illegal size.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset enters IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch addr, wdata, size, wen and unsigned.
  - Misaligned access → DONE with err = 1. Misaligned means half with addr[0] = 1, word with addr[1:0] ≠ 0, or size = 11.
  - Otherwise → REQ.
- REQ:
  - mem_req_valid = 1.
  - mem_addr, mem_wen, mem_wdata and mem_wmask are held stable until mem_req_ready.
  - On mem_req_ready → WAIT.
- WAIT:
  - On mem_rsp_valid → DONE.
  - Loads capture the extracted and extended data.
  - Stores ignore mem_rsp_rdata.
- DONE:
  - resp_valid = 1; resp_rdata and resp_err are held stable.
  - On resp_ready → IDLE.
- Store lane rules, with o = addr[1:0]:
  - byte: wmask = 0001 << o; wdata = {4{wdata[7:0]}}.
  - half: wmask = 0011 << o; wdata = {2{wdata[15:0]}}.
  - word: wmask = 1111; wdata unchanged.
- Load extraction:
  - byte = rdata[8*o+7 : 8*o].
  - half = rdata[8*o+15 : 8*o].
  - word = rdata.
  - Extend to 32 bits by sign or zero per req_unsigned. req_unsigned is ignored for word.
- mem_rsp_valid outside WAIT is ignored.
- req_valid outside IDLE is not accepted (req_ready = 0).

## Timing
- All outputs are decoded from state and registers; no combinational path from any input to any output.
- Reset values:
  - state = IDLE, so req_ready = 1.
  - mem_req_valid = 0, mem_wen = 0, mem_wmask = 0, mem_addr = 0, mem_wdata = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
- Minimum aligned latency, where cycle 0 is the req handshake:
  - cycle 1: mem_req_valid.
  - With mem_req_ready = 1 in cycle 1, the earliest mem_rsp_valid is cycle 2.
  - resp_valid is high in cycle 3.
- Misaligned access: resp_valid in cycle 1 with resp_err = 1; no memory activity.
- Backpressure:
  - mem_req_ready low stretches REQ indefinitely.
  - resp_ready low holds DONE indefinitely.
- Throughput: one transaction at a time. The next accept is the cycle after the resp handshake, i.e. IDLE follows DONE; no back-to-back accept in DONE.
- Reset mid-transaction (any state):
  - Returns to IDLE the next edge and drops all outstanding work.
  - A later stray mem_rsp_valid is ignored.

## Test plan
- Word store, then load: SW addr 0x80000010 data 0xDEADBEEF → mem_wmask 1111, mem_wdata 0xDEADBEEF. Then LW same address with memory returning 0xDEADBEEF → resp_rdata 0xDEADBEEF, resp_valid in cycle 3.
- Byte load extend: addr 0x80000013, memory word 0x80FF7F01. Signed LB → 0xFFFFFF80. LBU → 0x00000080.
- Half store lanes: SH addr 0x80000002 data 0x1234ABCD → mem_wmask 1100, mem_wdata 0xABCDABCD, mem_addr 0x80000000.
- Misaligned: LW addr 0x80000001 → resp_valid cycle 1, resp_err = 1, resp_rdata = 0, mem_req_valid never asserted.
- Backpressure: mem_req_ready low 5 cycles, then resp_ready low 3 cycles → all outputs stable throughout, req_ready = 0, exactly one mem request issued.
- Reset in WAIT: rst_n low for one edge while in WAIT, then mem_rsp_valid pulse → state IDLE, resp_valid stays 0, req_ready = 1.
